text_console: RTL and testbench
===============================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 60, text rows on screen.
REQ-003 Parameter ATTR_W, default 8, per-character attribute width (colour index).
REQ-004 Parameter BLINK_DIV, default 12500000, clock cycles per cursor blink half-period.
REQ-005 sys_clk  input  1  single clock; all state on rising edge.
REQ-006 clrn  input  1  reset, asynchronous, active-low.
REQ-007 ch_valid  input  1  character-stream write request.
REQ-008 ch_data  input  7  ASCII code or control code.
REQ-009 ch_attr  input  ATTR_W  attribute stored with printable characters.
REQ-010 ch_ready  output  1  console accepts ch_data this cycle.
REQ-011 row_addr  input  9  VGA pixel row, 0..ROWS*8-1.
REQ-012 col_addr  input  10  VGA pixel column, 0..COLS*8-1.
REQ-013 ascii  output  7  character code at the addressed cell, registered.
REQ-014 attr  output  ATTR_W  attribute at the addressed cell, registered.
REQ-015 font_row, font_col  output  3 each  row_addr[2:0] and col_addr[2:0], registered and aligned with ascii.
REQ-016 cursor_dot  output  1  addressed pixel lies on the visible cursor underline, registered.
REQ-017 cur_row  output  clog2(ROWS)  logical cursor row; cur_col  output  clog2(COLS)  cursor column.

Function
REQ-018 Storage: one ROWS*COLS-entry buffer of {ATTR_W, 7} bits; one write port (FSM) and one independent read port (display); both ports usable in the same cycle.
REQ-019 Scrolling uses a circular top-row pointer top (0..ROWS-1); physical row = (logical row + top) mod ROWS; address = physical row*COLS + column; no data is copied.
REQ-020 A transfer occurs on a cycle with ch_valid=1 and ch_ready=1; ch_ready=1 only in state IDLE.
REQ-021 FSM states: CLR_ALL, IDLE, CLR_LINE.
REQ-022 CLR_ALL writes {attr 0, 7'h20} to all ROWS*COLS entries, one per cycle, then goes to IDLE; duration exactly ROWS*COLS cycles.
REQ-023 Printable 0x20..0x7E: write {ch_attr, ch_data} at the cursor; cur_col+1; at cur_col=COLS-1, cur_col becomes 0 and a newline is performed.
REQ-024 0x0A newline: cur_col becomes 0; if cur_row<ROWS-1, cur_row+1; otherwise cur_row holds, top advances by 1 mod ROWS, and the FSM enters CLR_LINE.
REQ-025 CLR_LINE writes spaces (attr 0) to the COLS cells of the new bottom logical row, one per cycle, then returns to IDLE; ch_ready=0 for exactly COLS cycles.
REQ-026 0x0D: cur_col becomes 0.
REQ-027 0x08 backspace: if cur_col>0, cur_col-1 and write a space at the new position; at cur_col=0 there is no effect.
REQ-028 0x0C: cur_row and cur_col become 0, top becomes 0, and the FSM enters CLR_ALL.
REQ-029 Any other code is consumed with no effect.
REQ-030 Read path latency is 1 cycle: ascii, attr, font_row, font_col and cursor_dot reflect the row_addr/col_addr presented on the previous cycle.
REQ-031 If a write and a read hit the same address in the same cycle, the read returns the old data.
REQ-032 Blink: counter 0..BLINK_DIV-1; blink_on toggles at wrap.
REQ-033 cursor_dot=1 iff blink_on=1, the addressed cell equals the cursor's physical cell, and row_addr[2:0]=7.
REQ-034 Pixel addresses outside the COLS x ROWS area return ascii=0x20, attr=0 and cursor_dot=0.

Reset
REQ-035 While clrn=0: FSM in CLR_ALL with clear index 0; top, cur_row, cur_col, blink counter and blink_on all 0; ch_ready, cursor_dot, ascii, attr, font_row and font_col all 0.
REQ-036 After release of clrn, CLR_ALL runs to completion before ch_ready first asserts.
REQ-037 Reset asserted mid-CLR_LINE or mid-CLR_ALL aborts the operation immediately; the full clear restarts at release.

Verification
REQ-038 Release reset -> ch_ready=0 for 4800 cycles, then 1; every cell reads 0x20 / attr 0.
REQ-039 Send 'A' (0x41, attr 0x1F) -> cell (0,0) reads 0x41/0x1F one cycle after it is addressed; cur_col=1.
REQ-040 Send 80 printable characters -> cur_row=1, cur_col=0; the 80th character is at (0,79).
REQ-041 At cur_row=59, send 0x0A -> ch_ready low for 80 cycles; top=1; logical row 59 all spaces; old row 1 now displays at logical row 0.
REQ-042 Backspace at cur_col=0 -> no change; backspace at cur_col=5 -> cur_col=4 and cell 4 holds a space.
REQ-043 BLINK_DIV=4, cursor at (2,3), addressed pixel row 23, col 24..31 -> cursor_dot toggles every 4 cycles; cursor_dot=0 at pixel row 22.

Source files
------------

// File: rtl/text_console.sv
// Character-cell text console: ASCII stream writer with scrolling and clear
// engines, plus a one-cycle-latency display read port with blinking cursor.
module text_console #(
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int ATTR_W    = 8,
    parameter int BLINK_DIV = 12500000,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS)
) (
    input  logic              sys_clk,
    input  logic              clrn,
    input  logic              ch_valid,
    input  logic [6:0]        ch_data,
    input  logic [ATTR_W-1:0] ch_attr,
    output logic              ch_ready,
    input  logic [8:0]        row_addr,
    input  logic [9:0]        col_addr,
    output logic [6:0]        ascii,
    output logic [ATTR_W-1:0] attr,
    output logic [2:0]        font_row,
    output logic [2:0]        font_col,
    output logic              cursor_dot,
    output logic [RW-1:0]     cur_row,
    output logic [CW-1:0]     cur_col
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);
    localparam int BW    = $clog2(BLINK_DIV + 1);
    localparam int DW    = ATTR_W + 7;
    localparam logic [RW:0] ROWS_X = (RW + 1)'(ROWS);

    typedef enum logic [1:0] {ST_CLR_ALL = 2'd0, ST_IDLE = 2'd1, ST_CLR_LINE = 2'd2} state_t;

    state_t              state_r, state_n_s;
    logic [AW-1:0]       clr_idx_r, clr_idx_n_s;
    logic [RW-1:0]       top_r, top_n_s, cur_row_r, row_n_s;
    logic [CW-1:0]       cur_col_r, col_n_s;
    logic                ch_ready_r;
    logic                we_s;
    logic [AW-1:0]       waddr_s;
    logic [DW-1:0]       wdata_s;
    logic [BW-1:0]       blink_cnt_r;
    logic                blink_on_r;
    logic [6:0]          ascii_r;
    logic [ATTR_W-1:0]   attr_r;
    logic [2:0]          font_row_r, font_col_r;
    logic                cursor_dot_r;
    logic                in_range_s;
    logic [AW-1:0]       rd_addr_s, cur_addr_s;
    logic [RW-1:0]       cur_prow_s, bot_prow_s;

    logic [DW-1:0]       mem [CELLS];

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow, input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        phys_row = (sum >= ROWS_X) ? RW'(sum - ROWS_X) : sum[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        cell_addr = AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    assign cur_prow_s = phys_row(cur_row_r, top_r);
    assign cur_addr_s = cell_addr(cur_prow_s, cur_col_r);
    // The freshly exposed bottom logical row sits just above the new top.
    assign bot_prow_s = (top_r == {RW{1'b0}}) ? RW'(ROWS - 1) : top_r - RW'(1);

    assign in_range_s = ({3'b000, row_addr[8:3]} < 9'(ROWS)) && ({3'b000, col_addr[9:3]} < 10'(COLS));
    assign rd_addr_s  = in_range_s ? cell_addr(phys_row(RW'(row_addr[8:3]), top_r), CW'(col_addr[9:3]))
                                   : {AW{1'b0}};

    // Next-state, cursor update and write-port control.
    always_comb begin
        state_n_s   = state_r;
        clr_idx_n_s = clr_idx_r;
        top_n_s     = top_r;
        row_n_s     = cur_row_r;
        col_n_s     = cur_col_r;
        we_s        = 1'b0;
        waddr_s     = {AW{1'b0}};
        wdata_s     = {{ATTR_W{1'b0}}, 7'h20};
        case (state_r)
            ST_CLR_ALL: begin
                we_s    = 1'b1;
                waddr_s = clr_idx_r;
                if (clr_idx_r == AW'(CELLS - 1)) begin
                    clr_idx_n_s = {AW{1'b0}};
                    state_n_s   = ST_IDLE;
                end else begin
                    clr_idx_n_s = clr_idx_r + AW'(1);
                end
            end
            ST_CLR_LINE: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(bot_prow_s, CW'(clr_idx_r));
                if (clr_idx_r == AW'(COLS - 1)) begin
                    clr_idx_n_s = {AW{1'b0}};
                    state_n_s   = ST_IDLE;
                end else begin
                    clr_idx_n_s = clr_idx_r + AW'(1);
                end
            end
            ST_IDLE: begin
                if (ch_valid) begin
                    logic nl;
                    nl = 1'b0;
                    if (ch_data >= 7'h20 && ch_data <= 7'h7E) begin
                        we_s    = 1'b1;
                        waddr_s = cur_addr_s;
                        wdata_s = {ch_attr, ch_data};
                        if (cur_col_r == CW'(COLS - 1)) begin
                            nl = 1'b1;
                        end else begin
                            col_n_s = cur_col_r + CW'(1);
                        end
                    end else begin
                        case (ch_data)
                            7'h0A: nl = 1'b1;
                            7'h0D: col_n_s = {CW{1'b0}};
                            7'h08: begin
                                if (cur_col_r != {CW{1'b0}}) begin
                                    col_n_s = cur_col_r - CW'(1);
                                    we_s    = 1'b1;
                                    waddr_s = cell_addr(cur_prow_s, cur_col_r - CW'(1));
                                end else begin
                                    col_n_s = cur_col_r;
                                end
                            end
                            7'h0C: begin
                                row_n_s     = {RW{1'b0}};
                                col_n_s     = {CW{1'b0}};
                                top_n_s     = {RW{1'b0}};
                                clr_idx_n_s = {AW{1'b0}};
                                state_n_s   = ST_CLR_ALL;
                            end
                            default: col_n_s = cur_col_r;
                        endcase
                    end
                    if (nl) begin
                        col_n_s = {CW{1'b0}};
                        if (cur_row_r < RW'(ROWS - 1)) begin
                            row_n_s = cur_row_r + RW'(1);
                        end else begin
                            top_n_s     = (top_r == RW'(ROWS - 1)) ? {RW{1'b0}} : top_r + RW'(1);
                            clr_idx_n_s = {AW{1'b0}};
                            state_n_s   = ST_CLR_LINE;
                        end
                    end else begin
                        top_n_s = top_n_s;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            default: begin
                state_n_s   = ST_CLR_ALL;
                clr_idx_n_s = {AW{1'b0}};
            end
        endcase
    end

    // Control state, cursor and scroll pointer registers.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            state_r    <= ST_CLR_ALL;
            clr_idx_r  <= {AW{1'b0}};
            top_r      <= {RW{1'b0}};
            cur_row_r  <= {RW{1'b0}};
            cur_col_r  <= {CW{1'b0}};
            ch_ready_r <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            clr_idx_r  <= clr_idx_n_s;
            top_r      <= top_n_s;
            cur_row_r  <= row_n_s;
            cur_col_r  <= col_n_s;
            ch_ready_r <= (state_n_s == ST_IDLE);
        end
    end

    // Character buffer write port.
    always_ff @(posedge sys_clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    // Cursor blink timebase.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= 1'b0;
        end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= ~blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
        end
    end

    // Display read port; a same-cycle write to this cell is not yet visible.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            ascii_r      <= 7'h00;
            attr_r       <= {ATTR_W{1'b0}};
            font_row_r   <= 3'd0;
            font_col_r   <= 3'd0;
            cursor_dot_r <= 1'b0;
        end else begin
            font_row_r   <= row_addr[2:0];
            font_col_r   <= col_addr[2:0];
            cursor_dot_r <= blink_on_r && in_range_s && (rd_addr_s == cur_addr_s) && (row_addr[2:0] == 3'd7);
            if (in_range_s) begin
                {attr_r, ascii_r} <= mem[rd_addr_s];
            end else begin
                ascii_r <= 7'h20;
                attr_r  <= {ATTR_W{1'b0}};
            end
        end
    end

    assign ch_ready   = ch_ready_r;
    assign ascii      = ascii_r;
    assign attr       = attr_r;
    assign font_row   = font_row_r;
    assign font_col   = font_col_r;
    assign cursor_dot = cursor_dot_r;
    assign cur_row    = cur_row_r;
    assign cur_col    = cur_col_r;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: directed character stream, display reads
// checked by a monitor against expectations queued at issue time.
module tb_text_console;

    logic       sys_clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ch_valid = 1'b0;
    logic [6:0] ch_data = 7'h00;
    logic [7:0] ch_attr = 8'h00;
    logic       ch_ready;
    logic [8:0] row_addr = 9'd0;
    logic [9:0] col_addr = 10'd0;
    logic [6:0] ascii;
    logic [7:0] attr;
    logic [2:0] font_row, font_col;
    logic       cursor_dot;
    logic [5:0] cur_row;
    logic [6:0] cur_col;

    text_console #(.COLS(80), .ROWS(60), .ATTR_W(8), .BLINK_DIV(4)) dut (
        .sys_clk(sys_clk), .clrn(clrn), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_attr(ch_attr), .ch_ready(ch_ready), .row_addr(row_addr), .col_addr(col_addr),
        .ascii(ascii), .attr(attr), .font_row(font_row), .font_col(font_col),
        .cursor_dot(cursor_dot), .cur_row(cur_row), .cur_col(cur_col)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [6:0] a;
        logic [7:0] at;
        logic       d;
        logic [2:0] fr;
        logic [2:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic rd_req = 1'b0;
    logic rd_vld_d = 1'b0;

    always @(posedge sys_clk) rd_vld_d <= rd_req;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one read result per issued read, one cycle after issue.
    always @(negedge sys_clk) begin
        exp_t e;
        if (rd_vld_d) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = sb_q.pop_front();
                check("ascii", int'(ascii), int'(e.a));
                check("attr", int'(attr), int'(e.at));
                check("cursor_dot", int'(cursor_dot), int'(e.d));
                check("font_row", int'(font_row), int'(e.fr));
                check("font_col", int'(font_col), int'(e.fc));
            end
        end
    end

    task automatic push_exp(input int prow, input int pcol, input logic [6:0] ea, input logic [7:0] eat, input logic ed);
        exp_t e;
        e.a  = ea;
        e.at = eat;
        e.d  = ed;
        e.fr = 3'(prow);
        e.fc = 3'(pcol);
        sb_q.push_back(e);
    endtask

    task automatic read_px(input int prow, input int pcol, input logic [6:0] ea, input logic [7:0] eat, input logic ed);
        row_addr = 9'(prow);
        col_addr = 10'(pcol);
        rd_req   = 1'b1;
        push_exp(prow, pcol, ea, eat, ed);
        @(negedge sys_clk);
        rd_req = 1'b0;
    endtask

    task automatic read_cell(input int r, input int c, input logic [6:0] ea, input logic [7:0] eat);
        read_px(r * 8 + 3, c * 8 + 5, ea, eat, 1'b0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ch_ready && n < 6000) begin
            @(negedge sys_clk);
            n++;
        end
    endtask

    task automatic send(input logic [6:0] d, input logic [7:0] a);
        int n;
        wait_ready(n);
        if (!ch_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got ch_ready=0 expected 1 within 6000 cycles");
        end
        ch_valid = 1'b1;
        ch_data  = d;
        ch_attr  = a;
        @(negedge sys_clk);
        ch_valid = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int prev;
        int v0;

        repeat (3) @(negedge sys_clk);
        check("rst_ch_ready", int'(ch_ready), 0);
        check("rst_ascii", int'(ascii), 0);
        check("rst_attr", int'(attr), 0);
        check("rst_cursor_dot", int'(cursor_dot), 0);
        check("rst_font_row", int'(font_row), 0);
        check("rst_cur_row", int'(cur_row), 0);
        check("rst_cur_col", int'(cur_col), 0);

        clrn = 1'b1;
        wait_ready(n);
        check("clr_all_cycles", n, 4800);

        for (int r = 0; r < 60; r++) begin
            for (int c = 0; c < 80; c++) begin
                read_px(r * 8 + (c % 7), c * 8 + (r % 8), 7'h20, 8'h00, 1'b0);
            end
        end
        read_px(480, 0, 7'h20, 8'h00, 1'b0);
        read_px(0, 640, 7'h20, 8'h00, 1'b0);
        read_px(511, 1023, 7'h20, 8'h00, 1'b0);

        send(7'h41, 8'h1F);
        check("a_cur_col", int'(cur_col), 1);
        check("a_cur_row", int'(cur_row), 0);
        read_cell(0, 0, 7'h41, 8'h1F);

        for (int i = 1; i < 80; i++) send(7'(8'h30 + (i % 64)), 8'(i));
        check("wrap_cur_row", int'(cur_row), 1);
        check("wrap_cur_col", int'(cur_col), 0);
        read_cell(0, 79, 7'h3F, 8'h4F);
        read_cell(0, 1, 7'h31, 8'h01);
        read_cell(1, 0, 7'h20, 8'h00);

        send(7'h58, 8'h10);
        send(7'h59, 8'h10);
        check("pre_cr_col", int'(cur_col), 2);
        send(7'h0D, 8'h00);
        check("cr_col", int'(cur_col), 0);
        check("cr_row", int'(cur_row), 1);
        send(7'h08, 8'h00);
        check("bs0_col", int'(cur_col), 0);
        check("bs0_row", int'(cur_row), 1);
        read_cell(1, 0, 7'h58, 8'h10);

        for (int i = 0; i < 5; i++) send(7'(8'h61 + i), 8'h33);
        check("bs5_pre_col", int'(cur_col), 5);
        send(7'h08, 8'h00);
        check("bs5_col", int'(cur_col), 4);
        read_cell(1, 4, 7'h20, 8'h00);
        read_cell(1, 3, 7'h64, 8'h33);
        send(7'h01, 8'h77);
        send(7'h7F, 8'h77);
        check("other_col", int'(cur_col), 4);
        check("other_row", int'(cur_row), 1);
        read_cell(1, 4, 7'h20, 8'h00);

        for (int k = 0; k < 58; k++) send(7'h0A, 8'h00);
        check("nl_row59", int'(cur_row), 59);
        check("nl_col0", int'(cur_col), 0);
        send(7'h7E, 8'h44);
        send(7'h0A, 8'h00);
        wait_ready(n);
        check("clr_line_cycles", n, 80);
        check("scroll_row", int'(cur_row), 59);
        check("scroll_col", int'(cur_col), 0);
        read_cell(0, 0, 7'h61, 8'h33);
        read_cell(0, 3, 7'h64, 8'h33);
        read_cell(0, 4, 7'h20, 8'h00);
        read_cell(58, 0, 7'h7E, 8'h44);
        read_cell(59, 0, 7'h20, 8'h00);
        read_cell(59, 1, 7'h20, 8'h00);
        read_cell(59, 79, 7'h20, 8'h00);

        // Write and read the same cell in one cycle: read sees the old space.
        row_addr = 9'(59 * 8 + 3);
        col_addr = 10'd5;
        rd_req   = 1'b1;
        push_exp(59 * 8 + 3, 5, 7'h20, 8'h00, 1'b0);
        ch_valid = 1'b1;
        ch_data  = 7'h52;
        ch_attr  = 8'h55;
        @(negedge sys_clk);
        ch_valid = 1'b0;
        rd_req   = 1'b0;
        read_cell(59, 0, 7'h52, 8'h55);
        check("collide_col", int'(cur_col), 1);

        send(7'h0C, 8'h00);
        check("ff_row", int'(cur_row), 0);
        check("ff_col", int'(cur_col), 0);
        wait_ready(n);
        check("ff_clr_cycles", n, 4800);
        read_cell(0, 0, 7'h20, 8'h00);
        read_cell(1, 0, 7'h20, 8'h00);
        read_cell(59, 0, 7'h20, 8'h00);

        send(7'h0A, 8'h00);
        send(7'h0A, 8'h00);
        send(7'h41, 8'h01);
        send(7'h42, 8'h01);
        send(7'h43, 8'h01);
        check("blink_cur_row", int'(cur_row), 2);
        check("blink_cur_col", int'(cur_col), 3);

        row_addr = 9'd23;
        col_addr = 10'd24;
        @(negedge sys_clk);
        prev = int'(cursor_dot);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (int'(cursor_dot) == prev && n < 12);
        check("blink_edge_seen", int'(cursor_dot), 1 - prev);
        v0 = int'(cursor_dot);
        for (int j = 1; j < 16; j++) begin
            col_addr = 10'(24 + (j % 8));
            @(negedge sys_clk);
            check("blink_phase", int'(cursor_dot), v0 ^ ((j / 4) % 2));
        end
        row_addr = 9'd22;
        col_addr = 10'd24;
        for (int j = 0; j < 8; j++) begin
            @(negedge sys_clk);
            check("blink_row22", int'(cursor_dot), 0);
        end
        row_addr = 9'd23;
        col_addr = 10'd32;
        for (int j = 0; j < 8; j++) begin
            @(negedge sys_clk);
            check("blink_col32", int'(cursor_dot), 0);
        end

        repeat (2) @(negedge sys_clk);
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
